// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: grants one of the ALU and load writeback paths each cycle,
// registers the write port and tracks reserved destination registers in a busy scoreboard.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     ld_ready,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W-1:0]        write_addr,
  output logic [DATA_W-1:0]        write_data,
  output logic                     write_enable,
  output logic [(1<<ADDR_W)-1:0]   busy
);

  localparam int NREG = 1 << ADDR_W;

  logic [3:0]        r_wait_cnt;
  logic [ADDR_W-1:0] r_write_addr;
  logic [DATA_W-1:0] r_write_data;
  logic              r_write_enable;
  logic [NREG-1:0]   r_busy;

  logic              w_alu_pri;
  logic              w_alu_xfer;
  logic              w_ld_xfer;
  logic [NREG-1:0]   w_one;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_clr;

  // Handshake: a transfer occurs on a rising edge where valid && ready. Ready is a function
  // of both valids and the ALU wait counter only, never of the other ready, and a requester
  // may withdraw valid at any time; load wins contention until the ALU has waited too long.
  assign w_alu_pri  = (r_wait_cnt >= 4'(STARVE_LIMIT));
  assign ld_ready   = !reset && ld_valid && (!alu_valid || !w_alu_pri);
  assign alu_ready  = !reset && alu_valid && (!ld_valid || w_alu_pri);
  assign w_alu_xfer = alu_valid && alu_ready;
  assign w_ld_xfer  = ld_valid && ld_ready;

  assign w_one = {{(NREG-1){1'b0}}, 1'b1};
  assign w_set = rsv_valid ? (w_one << rsv_addr) : '0;
  assign w_clr = r_write_enable ? (w_one << r_write_addr) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write_enable <= 1'b0;
      r_write_addr   <= '0;
      r_write_data   <= '0;
    end else begin
      r_write_enable <= w_alu_xfer || w_ld_xfer;
      if (w_ld_xfer) begin
        r_write_addr <= ld_addr;
        r_write_data <= ld_data;
      end else if (w_alu_xfer) begin
        r_write_addr <= alu_addr;
        r_write_data <= alu_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= 4'd0;
    end else if (!alu_valid || w_alu_xfer) begin
      r_wait_cnt <= 4'd0;
    end else if (r_wait_cnt != 4'hF) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // A new reservation outlives a write to the same register landing in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign write_addr   = r_write_addr;
  assign write_data   = r_write_data;
  assign write_enable = r_write_enable;
  assign busy         = r_busy;

endmodule
